// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with key debounce, per-stage ack and fault latch
// Releases NUM_STAGES reset domains in order, each gated by its synchronized ack.
module reset_sequencer #(
   parameter int NUM_STAGES      = 3,
   parameter int HOLD_CYCLES     = 1000,
   parameter int STAGE_DELAY     = 64,
   parameter int ACK_TIMEOUT     = 4096,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          key,
   input  logic [NUM_STAGES-1:0]         stage_ack,
   output logic [NUM_STAGES-1:0]         rst_out,
   output logic                          ready,
   output logic                          fault,
   output logic [$clog2(NUM_STAGES)-1:0] stage
);

   localparam int SW      = $clog2(NUM_STAGES);
   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_DELAY)
                            ? ((HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT)
                            : ((STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT);
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] DELAY_LAST   = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] LAST_STAGE   = SW'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RELEASE,
      S_WAIT_ACK,
      S_RUN,
      S_FAULT
   } state_t;

   logic                  r_key_meta;
   logic                  r_key_sync;
   logic [NUM_STAGES-1:0] r_ack_meta;
   logic [NUM_STAGES-1:0] r_ack_sync;
   logic                  r_key_db;
   logic [DW-1:0]         r_db_cnt;
   logic                  r_press;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [SW-1:0]         r_stage;

   state_t                w_state_nxt;
   logic [CW-1:0]         w_cnt_nxt;
   logic [SW-1:0]         w_stage_nxt;
   logic [NUM_STAGES-1:0] w_rst_nxt;
   logic                  w_ack_cur;

   // Debounce counts consecutive cycles the synchronized key differs from the accepted level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_meta <= 1'b0;
         r_key_sync <= 1'b0;
         r_ack_meta <= '0;
         r_ack_sync <= '0;
         r_key_db   <= 1'b0;
         r_db_cnt   <= '0;
         r_press    <= 1'b0;
      end else begin
         r_key_meta <= key;
         r_key_sync <= r_key_meta;
         r_ack_meta <= stage_ack;
         r_ack_sync <= r_ack_meta;
         r_press    <= 1'b0;
         if (r_key_sync == r_key_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_key_db <= r_key_sync;
            r_press  <= r_key_sync;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   assign w_ack_cur = r_ack_sync[r_stage];

   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      case (r_state)
         S_HOLD: begin
            if (r_cnt == HOLD_LAST) w_state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (r_cnt == DELAY_LAST) w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (w_ack_cur) begin
               if (r_stage == LAST_STAGE) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_stage_nxt = r_stage + 1'b1;
                  w_state_nxt = S_RELEASE;
               end
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_state_nxt = S_FAULT;
            end
         end
         S_RUN: begin
            if (!(&r_ack_sync)) w_state_nxt = S_FAULT;
         end
         S_FAULT: begin
            w_state_nxt = S_FAULT;
         end
         default: begin
            w_state_nxt = S_HOLD;
         end
      endcase

      if (r_press) begin
         w_state_nxt = S_HOLD;
         w_stage_nxt = '0;
      end

      // Counter idles in RUN/FAULT so it can never wrap.
      if (r_press || (w_state_nxt != r_state)) begin
         w_cnt_nxt = '0;
      end else if ((r_state == S_RUN) || (r_state == S_FAULT)) begin
         w_cnt_nxt = r_cnt;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end

      w_rst_nxt = '1;
      case (w_state_nxt)
         S_RELEASE, S_WAIT_ACK: begin
            for (int i = 0; i < NUM_STAGES; i++) begin
               w_rst_nxt[i] = (SW'(i) > w_stage_nxt);
            end
         end
         S_RUN:   w_rst_nxt = '0;
         default: w_rst_nxt = '1;
      endcase
   end

   // Outputs are registered from the next-state decode so they track r_state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_stage <= '0;
         rst_out <= '1;
         ready   <= 1'b0;
         fault   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_stage <= w_stage_nxt;
         rst_out <= w_rst_nxt;
         ready   <= (w_state_nxt == S_RUN);
         fault   <= (w_state_nxt == S_FAULT);
      end
   end

   assign stage = r_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
// Expected output changes are queued by the stimulus and popped by a monitor on every observed change.
module tb_reset_sequencer;

   localparam int N  = 3;
   localparam int HC = 8;
   localparam int SD = 4;
   localparam int AT = 16;
   localparam int DB = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key;
   logic [2:0] stage_ack;
   logic [2:0] rst_out;
   logic       ready;
   logic       fault;
   logic [1:0] stage;

   logic [2:0] d1 = 3'b000;
   logic [2:0] d2 = 3'b000;
   logic [2:0] ack_lo;
   logic [2:0] ack_hi;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int last_cyc = 0;
   int rel_cyc = 0;
   logic [6:0] prev;
   bit mon_en = 1'b0;

   typedef struct {
      logic [6:0] val;
      int         gap;
      bit         from_rst;
   } exp_t;
   exp_t q[$];

   reset_sequencer #(
      .NUM_STAGES(N), .HOLD_CYCLES(HC), .STAGE_DELAY(SD),
      .ACK_TIMEOUT(AT), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key(key), .stage_ack(stage_ack),
      .rst_out(rst_out), .ready(ready), .fault(fault), .stage(stage)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream domains: each acks two cycles after its reset is released, unless forced.
   always @(negedge clk) begin
      d2 = d1;
      d1 = ~rst_out;
   end
   assign stage_ack = (d2 & ~ack_lo) | ack_hi;

   function automatic logic [6:0] pk(input logic [2:0] r, input logic rd, input logic f, input logic [1:0] s);
      return {r, rd, f, s};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic expect_out(input logic [6:0] v, input int gap, input bit from_rst);
      exp_t e;
      e.val = v;
      e.gap = gap;
      e.from_rst = from_rst;
      q.push_back(e);
   endtask

   // Stage s released means bits 0..s are low; ready follows once the last stage acks.
   task automatic expect_bringup(input bit from_rst);
      logic [2:0] ones;
      for (int s = 0; s < N; s++) begin
         ones = 3'b111;
         expect_out(pk(ones << (s + 1), 1'b0, 1'b0, 2'(s)), (s == 0) ? HC : -1, (s == 0) ? from_rst : 1'b0);
      end
      expect_out(pk(3'b000, 1'b1, 1'b0, 2'(N - 1)), -1, 1'b0);
   endtask

   function automatic bit cond(input int what);
      case (what)
         0: return ready === 1'b1;
         1: return fault === 1'b1;
         2: return (stage === 2'd1) && (rst_out === 3'b100);
         3: return (rst_out === 3'b111) && (ready === 1'b0) && (fault === 1'b0);
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int what, input int maxc, input string nm);
      int n;
      bit hit;
      n = 0;
      hit = cond(what);
      while (!hit && n < maxc) begin
         @(negedge clk);
         n++;
         hit = cond(what);
      end
      check(nm, 32'(hit), 32'd1);
   endtask

   task automatic press(input int h);
      @(negedge clk);
      key = 1'b1;
      repeat (h) @(negedge clk);
      key = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [6:0] cur;
      exp_t e;
      if (mon_en) begin
         cur = pk(rst_out, ready, fault, stage);
         if (cur !== prev) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_change: got %0h expected no change", cur);
            end else begin
               e = q.pop_front();
               check("out_seq", 32'(cur), 32'(e.val));
               if (e.gap >= 0)
                  check("seq_gap", 32'(cyc - (e.from_rst ? rel_cyc : last_cyc)), 32'(e.gap));
            end
            last_cyc = cyc;
            prev = cur;
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      key = 1'b0;
      ack_lo = 3'b000;
      ack_hi = 3'b000;
      repeat (3) @(negedge clk);
      check("reset_rst_out", 32'(rst_out), 32'h7);
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_fault", 32'(fault), 32'd0);
      check("reset_stage", 32'(stage), 32'd0);
      prev = pk(rst_out, ready, fault, stage);
      mon_en = 1'b1;

      expect_bringup(1'b1);
      rst_n = 1'b1;
      rel_cyc = cyc;
      wait_for(0, 200, "bringup_ready");
      check("bringup_fault", 32'(fault), 32'd0);

      repeat (6) begin
         int len;
         len = $urandom_range(1, 3);
         @(negedge clk);
         key = 1'b1;
         repeat (len) @(negedge clk);
         key = 1'b0;
         repeat ($urandom_range(3, 6)) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("glitch_ready", 32'(ready), 32'd1);

      expect_out(pk(3'b111, 1'b0, 1'b0, 2'd0), -1, 1'b0);
      expect_bringup(1'b0);
      press($urandom_range(DB, 10));
      wait_for(3, 100, "repress_hold");
      wait_for(0, 200, "repress_ready");

      repeat ($urandom_range(2, 20)) @(negedge clk);
      expect_out(pk(3'b111, 1'b0, 1'b1, 2'd2), -1, 1'b0);
      ack_lo = 3'b100;
      n = 0;
      while (fault !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n >= 1 && n <= 3) n_pass++;
      else $display("FAIL loss_latency: got %0d cycles required 1..3", n);
      check("loss_rst_out", 32'(rst_out), 32'h7);

      ack_lo = 3'b000;
      ack_hi = 3'b111;
      expect_out(pk(3'b111, 1'b0, 1'b0, 2'd0), -1, 1'b0);
      expect_bringup(1'b0);
      press($urandom_range(DB, 10));
      wait_for(3, 100, "recover_hold");
      wait_for(0, 200, "recover_ready");
      check("recover_fault", 32'(fault), 32'd0);

      expect_out(pk(3'b111, 1'b0, 1'b0, 2'd0), -1, 1'b0);
      expect_out(pk(3'b110, 1'b0, 1'b0, 2'd0), HC, 1'b0);
      expect_out(pk(3'b100, 1'b0, 1'b0, 2'd1), -1, 1'b0);
      expect_out(pk(3'b111, 1'b0, 1'b1, 2'd1), SD + AT, 1'b0);
      press($urandom_range(DB, 10));
      wait_for(3, 100, "timeout_hold");
      ack_hi = 3'b000;
      ack_lo = 3'b010;
      wait_for(1, 200, "timeout_fault");
      check("timeout_stage", 32'(stage), 32'd1);
      check("timeout_rst_out", 32'(rst_out), 32'h7);

      ack_lo = 3'b000;
      expect_out(pk(3'b111, 1'b0, 1'b0, 2'd0), -1, 1'b0);
      expect_out(pk(3'b110, 1'b0, 1'b0, 2'd0), HC, 1'b0);
      expect_out(pk(3'b100, 1'b0, 1'b0, 2'd1), -1, 1'b0);
      press($urandom_range(DB, 10));
      wait_for(3, 100, "async_hold");
      wait_for(2, 200, "async_release1");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      expect_out(pk(3'b111, 1'b0, 1'b0, 2'd0), -1, 1'b0);
      expect_bringup(1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_out", 32'(rst_out), 32'h7);
      check("async_stage", 32'(stage), 32'd0);
      #1 rst_n = 1'b1;
      rel_cyc = cyc;
      wait_for(0, 200, "async_restart_ready");

      repeat (20) @(negedge clk);
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
